// File: rtl/micro_waves_pkg.sv
// Shared types and reset constants for the microwave input conditioner.
// Optional INPUT_SYNC_EN adds a 2-flop synchronizer in front of all debouncers.
package micro_waves_pkg;

    localparam int KEY_W               = 10;
    localparam int CODE_W              = 4;
    localparam int RAW_W               = KEY_W + 4;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } key_state_t;

    localparam logic [KEY_W-1:0]  KEYBOARD_RST = '0;
    localparam logic [CODE_W-1:0] KEY_CODE_RST = '0;
    localparam logic              BTN_RST      = 1'b1;
    localparam logic              DOOR_RST     = 1'b0;

    // Raw bundle order: {door, clearn, stopn, startn, keypad}
    localparam logic [RAW_W-1:0] RAW_RST =
        {DOOR_RST, BTN_RST, BTN_RST, BTN_RST, KEYBOARD_RST};

    function automatic logic is_onehot(input logic [KEY_W-1:0] v);
        return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
    endfunction

    function automatic logic [CODE_W-1:0] key_index(input logic [KEY_W-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < KEY_W; i++) begin
            if (v[i]) idx = CODE_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/micro_waves_debounce_bit.sv
// Single-bit debouncer: output follows the input only after
// DEBOUNCE_CYCLES consecutive differing samples.
module micro_waves_debounce_bit
    import micro_waves_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sample,
    output logic level
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            level <= RST_VAL;
            cnt   <= '0;
        end else if (sample == level) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            level <= sample;
            cnt   <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/micro_waves_input_conditioner.sv
// Keypad and button conditioner for the microwave controller.
// Define INPUT_SYNC_EN to insert a 2-flop synchronizer on every raw input.
module micro_waves_input_conditioner
    import micro_waves_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [KEY_W-1:0]  keypad_raw,
    input  logic              startn_raw,
    input  logic              stopn_raw,
    input  logic              clearn_raw,
    input  logic              door_closed_raw,
    output logic [KEY_W-1:0]  keyboard,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_pulse,
    output logic              startn,
    output logic              stopn,
    output logic              clearn,
    output logic              door_closed
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [RAW_W-1:0] raw_vec;
    logic [RAW_W-1:0] smp;
    logic [KEY_W-1:0] s;

    assign raw_vec = {door_closed_raw, clearn_raw, stopn_raw,
                      startn_raw, keypad_raw};

`ifdef INPUT_SYNC_EN
    logic [RAW_W-1:0] sync_q1;
    logic [RAW_W-1:0] sync_q2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= RAW_RST;
            sync_q2 <= RAW_RST;
        end else begin
            sync_q1 <= raw_vec;
            sync_q2 <= sync_q1;
        end
    end

    assign smp = sync_q2;
`else
    assign smp = raw_vec;
`endif

    assign s = smp[KEY_W-1:0];

    key_state_t        state, state_n;
    logic [CW-1:0]     cnt, cnt_n, cnt_inc;
    logic [KEY_W-1:0]  cand, cand_n;
    logic [KEY_W-1:0]  kb_n;
    logic [CODE_W-1:0] code_n;
    logic              valid_n;
    logic              pulse_n;

    assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            keyboard  <= KEYBOARD_RST;
            key_code  <= KEY_CODE_RST;
            key_valid <= 1'b0;
            key_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            keyboard  <= kb_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_pulse <= pulse_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        kb_n    = keyboard;
        code_n  = key_code;
        valid_n = key_valid;
        pulse_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (is_onehot(s)) begin
                    cand_n  = s;
                    cnt_n   = CW'(1);
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (s != cand) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = HELD;
                    cnt_n   = '0;
                    kb_n    = cand;
                    code_n  = key_index(cand);
                    valid_n = 1'b1;
                    pulse_n = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            HELD: begin
                if (s != cand) begin
                    state_n = RELEASE;
                    cnt_n   = CW'(1);
                end
            end
            RELEASE: begin
                // Returning to the held key is a bounce, not a new press.
                if (s == '0) begin
                    if (cnt == LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        kb_n    = KEYBOARD_RST;
                        code_n  = KEY_CODE_RST;
                        valid_n = 1'b0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end else if (s == cand) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    micro_waves_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (BTN_RST)
    ) u_db_start (
        .clk   (clk),
        .reset (reset),
        .sample(smp[KEY_W]),
        .level (startn)
    );

    micro_waves_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (BTN_RST)
    ) u_db_stop (
        .clk   (clk),
        .reset (reset),
        .sample(smp[KEY_W+1]),
        .level (stopn)
    );

    micro_waves_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (BTN_RST)
    ) u_db_clear (
        .clk   (clk),
        .reset (reset),
        .sample(smp[KEY_W+2]),
        .level (clearn)
    );

    micro_waves_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (DOOR_RST)
    ) u_db_door (
        .clk   (clk),
        .reset (reset),
        .sample(smp[KEY_W+3]),
        .level (door_closed)
    );

endmodule

// File: tb/tb_micro_waves_input_conditioner.sv
// Scoreboard bench for micro_waves_input_conditioner (DEBOUNCE_CYCLES=4).
// Expected latency follows INPUT_SYNC_EN.
module tb_micro_waves_input_conditioner;

    localparam int DB = 4;
`ifdef INPUT_SYNC_EN
    localparam int LAT = DB + 2;
`else
    localparam int LAT = DB;
`endif

    logic       clk;
    logic       reset;
    logic [9:0] keypad_raw;
    logic       startn_raw, stopn_raw, clearn_raw, door_closed_raw;
    logic [9:0] keyboard;
    logic [3:0] key_code;
    logic       key_valid, key_pulse;
    logic       startn, stopn, clearn, door_closed;

    typedef struct packed {
        logic [9:0] kb;
        logic [3:0] code;
        logic       valid;
        logic       pulse;
        logic       startn;
        logic       stopn;
        logic       clearn;
        logic       door;
    } outs_t;

    typedef struct {
        int    cyc;
        outs_t o;
        string nm;
    } exp_t;

    exp_t  sb[$];
    exp_t  e;
    outs_t m;
    outs_t snap, prev;
    bit    first = 1'b1;
    int    cyc   = 0;
    int    total = 0;
    int    bad   = 0;

    micro_waves_input_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk            (clk),
        .reset          (reset),
        .keypad_raw     (keypad_raw),
        .startn_raw     (startn_raw),
        .stopn_raw      (stopn_raw),
        .clearn_raw     (clearn_raw),
        .door_closed_raw(door_closed_raw),
        .keyboard       (keyboard),
        .key_code       (key_code),
        .key_valid      (key_valid),
        .key_pulse      (key_pulse),
        .startn         (startn),
        .stopn          (stopn),
        .clearn         (clearn),
        .door_closed    (door_closed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic outs_t rst_o();
        outs_t o;
        o        = '0;
        o.startn = 1'b1;
        o.stopn  = 1'b1;
        o.clearn = 1'b1;
        return o;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ev(input int dly, input string nm);
        sb.push_back('{cyc: cyc + dly, o: m, nm: nm});
    endtask

    task automatic press(input int k);
        keypad_raw    = '0;
        keypad_raw[k] = 1'b1;
        m.kb          = '0;
        m.kb[k]       = 1'b1;
        m.code        = 4'(k);
        m.valid       = 1'b1;
        m.pulse       = 1'b1;
        ev(LAT, $sformatf("press%0d", k));
        m.pulse = 1'b0;
        ev(LAT + 1, $sformatf("pulse_end%0d", k));
    endtask

    task automatic release_key();
        keypad_raw = '0;
        m.kb       = '0;
        m.code     = '0;
        m.valid    = 1'b0;
        ev(LAT, "release");
    endtask

    // Monitor: every change on the outputs must match the next expectation.
    always @(negedge clk) begin
        snap.kb     = keyboard;
        snap.code   = key_code;
        snap.valid  = key_valid;
        snap.pulse  = key_pulse;
        snap.startn = startn;
        snap.stopn  = stopn;
        snap.clearn = clearn;
        snap.door   = door_closed;
        if (first || snap !== prev) begin
            first = 1'b0;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected: cyc=%0d got out=%h, want no change",
                         cyc, snap);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || snap !== e.o) begin
                    bad++;
                    $display("FAIL %s: got cyc=%0d out=%h, want cyc=%0d out=%h",
                             e.nm, cyc, snap, e.cyc, e.o);
                end
            end
        end
        prev = snap;
    end

    initial begin
        reset           = 1'b1;
        keypad_raw      = 10'b0000100011;
        startn_raw      = 1'b0;
        stopn_raw       = 1'b1;
        clearn_raw      = 1'b0;
        door_closed_raw = 1'b1;
        m               = rst_o();
        sb.push_back('{cyc: 1, o: m, nm: "reset"});
        tick(2);
        reset           = 1'b0;
        keypad_raw      = '0;
        startn_raw      = 1'b1;
        clearn_raw      = 1'b1;
        door_closed_raw = 1'b0;
        tick(5);

        // clean single key
        press(2);
        tick(12);
        release_key();
        tick(LAT + 4);

        // bouncing key 5
        for (int i = 0; i < 8; i++) begin
            keypad_raw = (i % 2 == 0) ? 10'b0000100000 : 10'b0;
            tick(1);
        end
        press(5);
        tick(10);
        release_key();
        tick(LAT + 4);

        // edge keys
        press(0);
        tick(LAT + 3);
        release_key();
        tick(LAT + 4);
        press(9);
        tick(LAT + 3);
        release_key();
        tick(LAT + 4);

        // two keys together: nothing happens
        keypad_raw = 10'b1000000100;
        tick(20);
        keypad_raw = '0;
        tick(LAT + 4);

        // short start glitch: nothing happens
        startn_raw = 1'b0;
        tick(3);
        startn_raw = 1'b1;
        tick(LAT + 4);

        // start press with door closing on the same cycle
        startn_raw      = 1'b0;
        door_closed_raw = 1'b1;
        m.startn        = 1'b0;
        m.door          = 1'b1;
        ev(LAT, "start_door");
        tick(8);
        startn_raw      = 1'b1;
        door_closed_raw = 1'b0;
        m.startn        = 1'b1;
        m.door          = 1'b0;
        ev(LAT, "start_up_door_open");
        tick(LAT + 4);

        stopn_raw  = 1'b0;
        clearn_raw = 1'b0;
        m.stopn    = 1'b0;
        m.clearn   = 1'b0;
        ev(LAT, "stop_clear_dn");
        tick(5);
        stopn_raw  = 1'b1;
        clearn_raw = 1'b1;
        m.stopn    = 1'b1;
        m.clearn   = 1'b1;
        ev(LAT, "stop_clear_up");
        tick(LAT + 4);

        // reset while key 9 is held
        press(9);
        tick(LAT + 3);
        reset = 1'b1;
        m     = rst_o();
        ev(1, "reset_held");
        tick(1);
        reset = 1'b0;
        press(9);
        tick(LAT + 3);
        release_key();
        tick(LAT + 4);

        tick(20);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: got no change, want cyc=%0d out=%h",
                     e.nm, e.cyc, e.o);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
